mpt_table_memory: RTL and testbench
===================================

Name: mpt_table_memory

Overview:
Memory-side responder for the walker memory master port: a word-addressed, SRAM-backed slave that serves MPTE reads and table-population writes over the req/gnt/valid memory protocol.
- Used as the table backing store in block-level benches and as the on-chip MPT region in integration.
- Fixed response latency; in-order responses; one response per granted request; configurable outstanding limit to exercise walker stalls.

Parameters:
MEMORY_DATA_WIDTH, 64, word width in bits; power of two, >= 32
MEMORY_ADDR_WIDTH, 64, byte address width
DEPTH, 1024, number of words in the array
BASE_ADDR, 0, byte address of word 0
RESP_LATENCY, 2, cycles from grant to response valid; >= 1
MAX_OUTSTANDING, 2, granted-but-unanswered request limit; 1..RESP_LATENCY

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
memory_slave_mem_req  in  1  request
memory_slave_mem_gnt  out  1  request accepted this cycle
memory_slave_mem_valid  out  1  response valid (no backpressure)
memory_slave_mem_addr  in  MEMORY_ADDR_WIDTH  byte address
memory_slave_mem_rdata  out  MEMORY_DATA_WIDTH  read data
memory_slave_mem_wdata  in  MEMORY_DATA_WIDTH  write data
memory_slave_mem_we  in  1  1 = write
memory_slave_mem_be  in  MEMORY_DATA_WIDTH/8  byte enables
memory_slave_mem_error  out  1  response error, qualified by valid

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: gnt=0, valid=0, rdata=0, error=0. Outstanding counter = 0. Latency pipeline cleared.
- Array contents are not cleared by reset.
- Reset mid-operation drops all in-flight responses; no valid appears after reset releases.
- Grant (combinational): gnt = req && (outstanding < MAX_OUTSTANDING || valid). A response retiring in the same cycle frees a slot.
- Accept = req && gnt. Address and control are sampled only on accept.
- Master holds addr/we/wdata/be stable while req is high and gnt is low.
- Decode: offset = addr - BASE_ADDR; index = offset >> log2(MEMORY_DATA_WIDTH/8).
  - Error if addr < BASE_ADDR.
  - Error if index >= DEPTH.
  - Error if addr is not word-aligned (low log2(bytes) bits nonzero).
  - be is not checked.
- Write accept (no error): for each set be[i], byte i of array[index] is updated at the accept clock edge. Response: rdata=0, error=0.
- Read accept (no error): rdata = array[index] as of the accept cycle. A write accepted in any earlier cycle is visible.
- Error accept: no array update; response rdata=0, error=1.
- Latency: a response for an accept at cycle t has valid=1 exactly at cycle t+RESP_LATENCY, for one cycle.
  - Responses are in order.
  - Back-to-back accepts give back-to-back valids.
- Outstanding counter: +1 on accept, -1 on valid, unchanged when both occur in the same cycle. Never exceeds MAX_OUTSTANDING; never underflows.
- rdata and error hold their last value when valid=0 (no toggling required). Benches check them only while valid=1.
- Throughput:
  - MAX_OUTSTANDING = RESP_LATENCY: one accept per cycle sustained.
  - MAX_OUTSTANDING < RESP_LATENCY: at most MAX_OUTSTANDING accepts per RESP_LATENCY cycles.
- Implementation: latency pipeline of RESP_LATENCY entries {valid, error, data} shifted every cycle; the array is a plain register/inferred RAM.

Test Plan:
1. Reset defaults: rst_ni low for 3 cycles, req=1 during reset -> gnt=0, valid=0; after release, no spurious valid.
2. Write/read round trip (defaults):
   - Stimulus: write addr 0x10, wdata 0xDEADBEEF_CAFEF00D, be=0xFF; then read 0x10, then write 0x10 with be=0x0F, wdata 0x11111111_22222222, then read 0x10.
   - Required: each valid arrives 2 cycles after its gnt, error=0. First read returns 0xDEADBEEF_CAFEF00D; second read returns 0xDEADBEEF_22222222.
3. Errors:
   - Stimulus: read 0x13 (misaligned); read BASE_ADDR+8*DEPTH; write 0x2000 with DEPTH=1024.
   - Required: each gives valid with error=1, rdata=0. A follow-up read of word 0x2000>>3 after rebuilding with DEPTH=2048 shows the contents unchanged.
4. Throttling:
   - Stimulus: RESP_LATENCY=4, MAX_OUTSTANDING=2, req held high for 8 reads.
   - Required: gnt pattern 1,1,0,0,1,1,0,0 per 4-cycle window; valids in order; outstanding never exceeds 2.
5. Full throughput and boundary:
   - Stimulus: RESP_LATENCY=MAX_OUTSTANDING=3, 16 consecutive reads across the last and first words.
   - Required: 16 consecutive gnt cycles, 16 consecutive valid cycles starting at accept+3, in-order data.
6. Reset mid-flight: assert rst_ni low 1 cycle after 2 accepts -> neither response appears; the next request after reset is granted normally.

Source files
------------

// File: rtl/mpt_table_memory.sv
// mpt_table_memory: word-addressed SRAM-backed responder for the walker memory master port.
// Serves MPTE reads and table-population writes over the req/gnt/valid protocol with a fixed
// response latency, in-order responses and a configurable outstanding-request limit.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   memory_slave_mem_req     request from master
//   memory_slave_mem_gnt     request accepted this cycle (combinational)
//   memory_slave_mem_addr    byte address
//   memory_slave_mem_we      1 = write
//   memory_slave_mem_wdata   write data
//   memory_slave_mem_be      byte enables for writes
//   memory_slave_mem_valid   response valid (no backpressure)
//   memory_slave_mem_rdata   read data, qualified by valid
//   memory_slave_mem_error   decode error, qualified by valid
module mpt_table_memory #(
  parameter int unsigned                  MEMORY_DATA_WIDTH = 64,
  parameter int unsigned                  MEMORY_ADDR_WIDTH = 64,
  parameter int unsigned                  DEPTH             = 1024,
  parameter logic [MEMORY_ADDR_WIDTH-1:0] BASE_ADDR         = '0,
  parameter int unsigned                  RESP_LATENCY      = 2,
  parameter int unsigned                  MAX_OUTSTANDING   = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           memory_slave_mem_req,
  output logic                           memory_slave_mem_gnt,
  output logic                           memory_slave_mem_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]   memory_slave_mem_addr,
  output logic [MEMORY_DATA_WIDTH-1:0]   memory_slave_mem_rdata,
  input  logic [MEMORY_DATA_WIDTH-1:0]   memory_slave_mem_wdata,
  input  logic                           memory_slave_mem_we,
  input  logic [MEMORY_DATA_WIDTH/8-1:0] memory_slave_mem_be,
  output logic                           memory_slave_mem_error
);

  localparam int unsigned Bytes     = MEMORY_DATA_WIDTH / 8;
  localparam int unsigned ByteShift = $clog2(Bytes);
  localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned Lat       = RESP_LATENCY;

  // Storage array; deliberately not reset so it maps onto RAM.
  logic [MEMORY_DATA_WIDTH-1:0] mem_q [DEPTH];

  // Address decode
  logic [MEMORY_ADDR_WIDTH-1:0] offset;
  logic [MEMORY_ADDR_WIDTH-1:0] word_idx;
  logic [IdxW-1:0]              mem_idx;
  logic                         below_base;
  logic                         misaligned;
  logic                         out_of_range;
  logic                         dec_err;

  always_comb begin
    offset       = memory_slave_mem_addr - BASE_ADDR;
    word_idx     = offset >> ByteShift;
    mem_idx      = word_idx[IdxW-1:0];
    below_base   = memory_slave_mem_addr < BASE_ADDR;
    misaligned   = |memory_slave_mem_addr[ByteShift-1:0];
    out_of_range = word_idx >= MEMORY_ADDR_WIDTH'(DEPTH);
    dec_err      = below_base | misaligned | out_of_range;
  end

  // Outstanding tracking and grant
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            resp_valid;

  // A response retiring this cycle frees its slot for a new accept in the same cycle.
  assign memory_slave_mem_gnt = rst_ni & memory_slave_mem_req &
                                ((cnt_q < CntW'(MAX_OUTSTANDING)) | resp_valid);
  assign accept = memory_slave_mem_req & memory_slave_mem_gnt;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, resp_valid})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Byte-merged write word
  logic                         wr_en;
  logic [MEMORY_DATA_WIDTH-1:0] wr_word;

  assign wr_en = accept & memory_slave_mem_we & ~dec_err;

  always_comb begin
    wr_word = mem_q[mem_idx];
    for (int unsigned b = 0; b < Bytes; b++) begin
      if (memory_slave_mem_be[b]) begin
        wr_word[8*b +: 8] = memory_slave_mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[mem_idx] <= wr_word;
    end
  end

  // Response pipeline. Stage 0 data/error hold when nothing is accepted, so the last stage
  // always carries the most recent response that has retired and rdata/error stay stable
  // between valids.
  logic [Lat-1:0]                        pipe_valid_q, pipe_valid_d;
  logic [Lat-1:0]                        pipe_err_q, pipe_err_d;
  logic [Lat-1:0][MEMORY_DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
  logic [MEMORY_DATA_WIDTH-1:0]          resp_data;

  // Read data is the array as of the accept cycle; writes and errors answer with zero.
  assign resp_data = (dec_err | memory_slave_mem_we) ? '0 : mem_q[mem_idx];

  always_comb begin
    pipe_valid_d    = pipe_valid_q;
    pipe_err_d      = pipe_err_q;
    pipe_data_d     = pipe_data_q;
    pipe_valid_d[0] = accept;
    if (accept) begin
      pipe_err_d[0]  = dec_err;
      pipe_data_d[0] = resp_data;
    end
    for (int unsigned i = 1; i < Lat; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_err_d[i]   = pipe_err_q[i-1];
      pipe_data_d[i]  = pipe_data_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      pipe_data_q  <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_err_q   <= pipe_err_d;
      pipe_data_q  <= pipe_data_d;
    end
  end

  assign resp_valid             = pipe_valid_q[Lat-1];
  assign memory_slave_mem_valid = resp_valid;
  assign memory_slave_mem_error = pipe_err_q[Lat-1];
  assign memory_slave_mem_rdata = pipe_data_q[Lat-1];

endmodule

// File: tb/tb_mpt_table_memory.sv
// Bench for mpt_table_memory. Two instances: A (defaults: latency 2, limit 2, base 0) and
// B (latency 4, limit 2, base 0x1000). A queue-based reference model predicts gnt, valid,
// error and rdata every cycle; directed sequences pin the model with literal values.
module tb_mpt_table_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        gnt   [2];
  logic        vld   [2];
  logic [63:0] addr  [2];
  logic [63:0] rdata [2];
  logic [63:0] wdata [2];
  logic        we    [2];
  logic [7:0]  be    [2];
  logic        err   [2];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mpt_table_memory u_dut_a (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .memory_slave_mem_req   (req[0]),
    .memory_slave_mem_gnt   (gnt[0]),
    .memory_slave_mem_valid (vld[0]),
    .memory_slave_mem_addr  (addr[0]),
    .memory_slave_mem_rdata (rdata[0]),
    .memory_slave_mem_wdata (wdata[0]),
    .memory_slave_mem_we    (we[0]),
    .memory_slave_mem_be    (be[0]),
    .memory_slave_mem_error (err[0])
  );

  mpt_table_memory #(
    .BASE_ADDR       (64'h1000),
    .RESP_LATENCY    (4),
    .MAX_OUTSTANDING (2)
  ) u_dut_b (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .memory_slave_mem_req   (req[1]),
    .memory_slave_mem_gnt   (gnt[1]),
    .memory_slave_mem_valid (vld[1]),
    .memory_slave_mem_addr  (addr[1]),
    .memory_slave_mem_rdata (rdata[1]),
    .memory_slave_mem_wdata (wdata[1]),
    .memory_slave_mem_we    (we[1]),
    .memory_slave_mem_be    (be[1]),
    .memory_slave_mem_error (err[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int maxo(input int k);
    return (k == 0) ? 2 : 2;
  endfunction

  function automatic longint unsigned base(input int k);
    return (k == 0) ? 64'h0 : 64'h1000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s @cyc %0d: timed out", name, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mem_m [longint unsigned];
  logic [63:0] kn_m  [longint unsigned];
  int          cnt_m [2];
  int          hd    [2];
  int          tl    [2];
  int          q_due [2][16];
  logic [63:0] q_dat [2][16];
  logic [63:0] q_msk [2][16];
  logic        q_err [2][16];
  // response log used by directed checks
  int          log_n   [2];
  logic [63:0] log_dat [2][256];
  logic        log_err [2][256];
  int          log_cyc [2][256];
  int          iss     [2];

  longint unsigned m_a, m_off, m_key;
  logic            m_e, m_mv, m_mg;
  logic [63:0]     m_d, m_k;

  initial begin
    for (int k = 0; k < 2; k++) begin
      cnt_m[k] = 0; hd[k] = 0; tl[k] = 0; log_n[k] = 0; iss[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check("reset_gnt", {63'd0, gnt[k]}, 64'd0);
        check("reset_valid", {63'd0, vld[k]}, 64'd0);
        check("reset_rdata", rdata[k], 64'd0);
        check("reset_error", {63'd0, err[k]}, 64'd0);
        cnt_m[k] = 0; hd[k] = 0; tl[k] = 0;
      end else begin
        m_mv = (cnt_m[k] > 0) && (q_due[k][hd[k]] == cyc);
        // gnt uses the occupancy before this cycle's retirement
        m_mg = req[k] && ((cnt_m[k] < maxo(k)) || m_mv);
        check("valid", {63'd0, vld[k]}, {63'd0, m_mv});
        if (m_mv) begin
          check("error", {63'd0, err[k]}, {63'd0, q_err[k][hd[k]]});
          check("rdata", rdata[k] & q_msk[k][hd[k]], q_dat[k][hd[k]] & q_msk[k][hd[k]]);
          log_dat[k][log_n[k] % 256] = rdata[k];
          log_err[k][log_n[k] % 256] = err[k];
          log_cyc[k][log_n[k] % 256] = cyc;
          log_n[k]++;
          hd[k] = (hd[k] + 1) % 16;
          cnt_m[k]--;
        end
        check("gnt", {63'd0, gnt[k]}, {63'd0, m_mg});
        if (req[k] && m_mg) begin
          m_a   = addr[k];
          m_off = m_a - base(k);
          m_e   = (m_a < base(k)) || (m_a % 8 != 0) || (m_off / 8 >= 1024);
          m_key = (longint'(k) << 32) | (m_off / 8);
          m_d   = 64'd0;
          m_k   = '1;
          if (!m_e && we[k]) begin
            if (!mem_m.exists(m_key)) begin
              mem_m[m_key] = 64'd0;
              kn_m[m_key]  = 64'd0;
            end
            for (int b = 0; b < 8; b++) begin
              if (be[k][b]) begin
                mem_m[m_key][8*b +: 8] = wdata[k][8*b +: 8];
                kn_m[m_key][8*b +: 8]  = 8'hFF;
              end
            end
          end else if (!m_e) begin
            m_d = mem_m.exists(m_key) ? mem_m[m_key] : 64'd0;
            m_k = kn_m.exists(m_key) ? kn_m[m_key] : 64'd0;
          end
          q_due[k][tl[k]] = cyc + lat(k);
          q_dat[k][tl[k]] = m_d;
          q_msk[k][tl[k]] = m_k;
          q_err[k][tl[k]] = m_e;
          tl[k] = (tl[k] + 1) % 16;
          cnt_m[k]++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Called and returning at posedge+1. acc = accept cycle, idx = response log index.
  task automatic do_req(input int k, input logic [63:0] a, input logic w, input logic [63:0] d,
                        input logic [7:0] b, output int acc, output int idx);
    int g = 0;
    req[k] = 1'b1; addr[k] = a; we[k] = w; wdata[k] = d; be[k] = b;
    acc = -1;
    while (acc < 0 && g < 50) begin
      @(negedge clk);
      if (gnt[k]) acc = cyc;
      g++;
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
    idx = iss[k];
    if (acc < 0) timeout("grant_wait");
    else iss[k]++;
  endtask

  task automatic wait_resp(input int k, input int idx);
    int g = 0;
    while (log_n[k] <= idx && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    if (log_n[k] <= idx) timeout("response_wait");
  endtask

  task automatic req_chk(input int k, input logic [63:0] a, input logic w, input logic [63:0] d,
                         input logic [7:0] b, input logic exp_err, input logic chk_data,
                         input logic [63:0] exp_data);
    int acc, idx;
    do_req(k, a, w, d, b, acc, idx);
    if (acc >= 0) begin
      wait_resp(k, idx);
      if (log_n[k] > idx) begin
        check("lit_latency", 64'(log_cyc[k][idx % 256] - acc), 64'(lat(k)));
        check("lit_error", {63'd0, log_err[k][idx % 256]}, {63'd0, exp_err});
        if (chk_data) check("lit_rdata", log_dat[k][idx % 256], exp_data);
      end
    end
  endtask

  function automatic logic [63:0] pick_addr(input int k);
    int r = $urandom_range(0, 9);
    int w = $urandom_range(0, 7);
    longint unsigned idx = (w < 4) ? longint'(w) : longint'(1016 + w);
    case (r)
      6:       return base(k) + idx * 8 + longint'($urandom_range(1, 7));
      7:       return base(k) + 8 * 1024;
      8:       return base(k) + 8 * longint'($urandom_range(1025, 100000));
      9:       return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : base(k) - 8;
      default: return base(k) + idx * 8;
    endcase
  endfunction

  task automatic rand_drive(input int k, input int n);
    int   acc = 0;
    int   g = 0;
    logic took = 1'b1;
    while (acc < n && g < n * 20) begin
      if (!req[k] || took) begin
        req[k]   = ($urandom_range(0, 3) != 0);
        addr[k]  = pick_addr(k);
        we[k]    = $urandom_range(0, 1) == 1;
        wdata[k] = {$urandom, $urandom};
        be[k]    = 8'($urandom);
      end
      @(negedge clk);
      took = req[k] && gnt[k];
      if (took) acc++;
      @(posedge clk); #1;
      g++;
    end
    req[k] = 1'b0;
    iss[k] += acc;
  endtask

  // ---------------- directed + random sequence ----------------
  int          acc_v [16];
  int          ix_v  [16];
  int          first;
  int          saved;
  int          n_acc;
  int          ncy;
  logic [7:0]  pat;
  logic [7:0]  bb;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b1; addr[k] = base(k); we[k] = 1'b0; wdata[k] = '0; be[k] = '0;
    end
    // reset held with req high
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // write/read round trip on A
    req_chk(0, 64'h10, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0, 1'b1, 64'd0);
    req_chk(0, 64'h10, 1'b0, 64'd0, 8'h00, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D);
    req_chk(0, 64'h10, 1'b1, 64'h11111111_22222222, 8'h0F, 1'b0, 1'b1, 64'd0);
    req_chk(0, 64'h10, 1'b0, 64'd0, 8'h00, 1'b0, 1'b1, 64'hDEADBEEF_22222222);

    // decode errors; erroring writes must not touch the array
    req_chk(0, 64'h13, 1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 64'd0);
    req_chk(0, 64'h2000, 1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 64'd0);
    req_chk(0, 64'h2000, 1'b1, 64'h5555_5555_5555_5555, 8'hFF, 1'b1, 1'b1, 64'd0);
    req_chk(0, 64'h15, 1'b1, 64'h0, 8'hFF, 1'b1, 1'b1, 64'd0);
    req_chk(0, 64'h10, 1'b0, 64'd0, 8'h00, 1'b0, 1'b1, 64'hDEADBEEF_22222222);
    req_chk(1, 64'h0FF8, 1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 64'd0);
    req_chk(1, 64'h3000, 1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 64'd0);

    // throttling on B: preload words 0..7, then hold req for 8 reads
    for (int i = 0; i < 8; i++) begin
      bb = 8'(i + 1);
      req_chk(1, 64'h1000 + 64'(i * 8), 1'b1, {8{bb}}, 8'hFF, 1'b0, 1'b1, 64'd0);
    end
    first = iss[1];
    n_acc = 0; ncy = 0; pat = '0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 64'h1000;
    while (n_acc < 8 && ncy < 100) begin
      @(negedge clk);
      if (ncy < 8) pat[7 - ncy] = gnt[1];
      if (gnt[1]) n_acc++;
      ncy++;
      @(posedge clk); #1;
      addr[1] = 64'h1000 + 64'(n_acc * 8);
    end
    req[1] = 1'b0;
    iss[1] += n_acc;
    check("throttle_gnt_pattern", {56'd0, pat}, {56'd0, 8'b1100_1100});
    wait_resp(1, first + 7);
    for (int i = 0; i < 8; i++) begin
      bb = 8'(i + 1);
      check("throttle_order", log_dat[1][(first + i) % 256], {8{bb}});
    end

    // full throughput on A across the last and first words
    for (int i = 0; i < 16; i++) begin
      int w;
      w = (i < 8) ? 1016 + i : i - 8;
      req_chk(0, 64'(w * 8), 1'b1, {32'(w), ~32'(w)}, 8'hFF, 1'b0, 1'b0, 64'd0);
    end
    for (int i = 0; i < 16; i++) begin
      int w;
      w = (i < 8) ? 1016 + i : i - 8;
      do_req(0, 64'(w * 8), 1'b0, 64'd0, 8'h00, acc_v[i], ix_v[i]);
    end
    wait_resp(0, ix_v[15]);
    for (int i = 0; i < 16; i++) begin
      int w;
      w = (i < 8) ? 1016 + i : i - 8;
      check("thru_accept_cycle", 64'(acc_v[i] - acc_v[0]), 64'(i));
      check("thru_valid_cycle", 64'(log_cyc[0][ix_v[i] % 256] - acc_v[0]), 64'(i + 2));
      check("thru_rdata", log_dat[0][ix_v[i] % 256], {32'(w), ~32'(w)});
    end

    // reset mid-flight on B: two accepts, reset one cycle later
    saved = log_n[1];
    do_req(1, 64'h1000, 1'b0, 64'd0, 8'h00, acc_v[0], ix_v[0]);
    do_req(1, 64'h1008, 1'b0, 64'd0, 8'h00, acc_v[1], ix_v[1]);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("dropped_responses", 64'(log_n[1]), 64'(saved));
    iss[1] = log_n[1];
    req_chk(1, 64'h1000, 1'b0, 64'd0, 8'h00, 1'b0, 1'b1, 64'h0101_0101_0101_0101);

    // randomized traffic on both instances
    fork
      rand_drive(0, 300);
      rand_drive(1, 300);
    join
    repeat (10) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
